// File: rtl/noc_pkt_pkg.sv
// Shared packet layout and slot state encoding for the packet routing stage.
package noc_pkt_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 7;
    localparam int PKT_W  = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Order-preserving synchronous FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [OCC_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; occupancy guards every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/packet_dest_router.sv
// Steers {addr, data} packets to a local sink (address stripped) or onward,
// in strict arrival order, with per-port delivery counters.
module packet_dest_router
    import noc_pkt_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOCAL_ADDR = '0,
    parameter int                FIFO_DEPTH = 2,
    parameter int                CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              _RESET,
    input  logic [PKT_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] loc_data,
    output logic              loc_valid,
    input  logic              loc_ready,
    output logic [PKT_W-1:0]  fwd_data,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    output logic [CNT_W-1:0]  loc_count,
    output logic [CNT_W-1:0]  fwd_count
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    pkt_t             head;
    logic             fifo_empty, unused_fifo_full;
    logic [OCC_W-1:0] fifo_count;
    logic             pop, head_local, loc_load, fwd_load;
    logic             loc_fire, fwd_fire, loc_free, fwd_free;

    slot_state_e       loc_state_q, loc_state_d, fwd_state_q, fwd_state_d;
    logic [DATA_W-1:0] loc_data_q;
    pkt_t              fwd_data_q;
    logic [CNT_W-1:0]  loc_count_q, fwd_count_q;

    // Registered occupancy only: a same-cycle pop never opens a full FIFO.
    assign in_ready = _RESET && (fifo_count < OCC_W'(FIFO_DEPTH));

    sync_fifo #(
        .WIDTH(PKT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_in_fifo (
        .clk    (CLK),
        .rst_n  (_RESET),
        .push_i (in_valid && in_ready),
        .wdata_i(in_data),
        .pop_i  (pop),
        .rdata_o(head),
        .full_o (unused_fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign loc_fire   = loc_valid && loc_ready;
    assign fwd_fire   = fwd_valid && fwd_ready;
    assign loc_free   = (loc_state_q == SLOT_EMPTY) || loc_fire;
    assign fwd_free   = (fwd_state_q == SLOT_EMPTY) || fwd_fire;
    assign head_local = (head.addr == LOCAL_ADDR);

    // Only the head may move; a blocked head stalls packets for the other port too.
    assign pop      = !fifo_empty && (head_local ? loc_free : fwd_free);
    assign loc_load = pop && head_local;
    assign fwd_load = pop && !head_local;

    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            loc_state_q <= SLOT_EMPTY;
            fwd_state_q <= SLOT_EMPTY;
            loc_data_q  <= '0;
            fwd_data_q  <= '0;
            loc_count_q <= '0;
            fwd_count_q <= '0;
        end else begin
            loc_state_q <= loc_state_d;
            fwd_state_q <= fwd_state_d;
            if (loc_load) loc_data_q <= head.data;
            if (fwd_load) fwd_data_q <= head;
            if (loc_fire) loc_count_q <= loc_count_q + CNT_W'(1);
            if (fwd_fire) fwd_count_q <= fwd_count_q + CNT_W'(1);
        end
    end

    // NOTE: each next-state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        loc_state_d = loc_state_q;
        fwd_state_d = fwd_state_q;
        case (loc_state_q)
            SLOT_EMPTY: if (loc_load) loc_state_d = SLOT_FULL;
            SLOT_FULL:  if (loc_fire && !loc_load) loc_state_d = SLOT_EMPTY;
            default:    loc_state_d = SLOT_EMPTY;
        endcase
        case (fwd_state_q)
            SLOT_EMPTY: if (fwd_load) fwd_state_d = SLOT_FULL;
            SLOT_FULL:  if (fwd_fire && !fwd_load) fwd_state_d = SLOT_EMPTY;
            default:    fwd_state_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        loc_valid = (loc_state_q == SLOT_FULL);
        fwd_valid = (fwd_state_q == SLOT_FULL);
        loc_data  = loc_data_q;
        fwd_data  = fwd_data_q;
        loc_count = loc_count_q;
        fwd_count = fwd_count_q;
    end

endmodule

// File: doc/packet_dest_router.md
Name: packet_dest_router

Overview:
- Clocked stage directly downstream of the address/data concatenation stage.
- Consumes {addr, data} packets and steers each one by its address field:
  - packets addressed to this node go to a local sink, with the address stripped;
  - all other packets go onward, unchanged, on a forward port.
- Order-preserving input FIFO, one registered output slot per port, and per-port delivered-packet counters.

Parameters:
ADDR_W, 4, address field width (packet MSBs)
DATA_W, 7, data field width (packet LSBs)
PKT_W, ADDR_W+DATA_W (11), packet width
LOCAL_ADDR, 4'd0, address treated as local
FIFO_DEPTH, 2, input FIFO entries; power of 2, >=2
CNT_W, 16, width of each delivered-packet counter

Ports:
CLK  input  1  clock; all state updates on rising edge
_RESET  input  1  synchronous, active-low reset
in_data  input  PKT_W  packet = {addr[PKT_W-1:DATA_W], data[DATA_W-1:0]}
in_valid  input  1  upstream offers in_data
in_ready  output  1  block accepts a packet this cycle
loc_data  output  DATA_W  data field of a local packet
loc_valid  output  1  local slot holds a packet
loc_ready  input  1  local sink accepts
fwd_data  output  PKT_W  full packet, passed through unchanged
fwd_valid  output  1  forward slot holds a packet
fwd_ready  input  1  forward sink accepts
loc_count  output  CNT_W  local packets delivered
fwd_count  output  CNT_W  forward packets delivered

Behaviour:
- Reset (_RESET==0 at a rising CLK):
  - FIFO emptied; loc_valid=0, fwd_valid=0; loc_data=0, fwd_data=0; both counters 0.
  - in_ready is forced to 0 combinationally while _RESET is low.
  - Reset mid-operation discards all buffered and in-slot packets; nothing is delivered after reset.
- Handshakes: a transfer occurs on any cycle where valid && ready at the rising edge.
  - Outputs hold data stable while valid && !ready; valid never drops without a transfer.
  - in_ready depends only on registered FIFO occupancy: in_ready = _RESET && (count < FIFO_DEPTH).
- Input FIFO:
  - Push on in_valid && in_ready.
  - No same-cycle bypass: when full, in_ready=0 even if a pop occurs that cycle.
  - Push and pop in the same cycle (not full) leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Routing decision: head address == LOCAL_ADDR selects local, otherwise forward.
- Output slots: each is a 2-state machine, EMPTY or FULL, indicated by *_valid.
  - EMPTY -> FULL when dispatch loads the slot.
  - FULL -> EMPTY on a sink transfer with no new load.
  - FULL -> FULL on a sink transfer plus a same-cycle load (back-to-back delivery).
- Dispatch: the head pops when FIFO is non-empty and its target slot is EMPTY or being drained this cycle (valid && ready).
  - The target slot loads on the same edge as the pop.
  - At most one pop per cycle.
- Ordering and blocking:
  - Strict in-order dispatch: a head blocked on one port also blocks later packets bound for the other port (head-of-line blocking by design).
  - Ordering within each port is preserved.
- Latency with an idle pipe: accept at edge N; data at FIFO head after edge N; slot valid after edge N+1.
  - Minimum two cycles from input transfer to output valid.
  - Throughput is one packet per cycle when sinks are always ready.
- Counters:
  - loc_count increments on each loc_valid && loc_ready transfer; fwd_count likewise on the forward port.
  - Each counter wraps modulo 2^CNT_W.
- Widths:
  - loc_data = head[DATA_W-1:0].
  - fwd_data = head unchanged.
  - Address compare is exactly ADDR_W bits.

Decomposition:
- Package noc_pkt_pkg holds:
  - ADDR_W, DATA_W, PKT_W constants;
  - typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} pkt_t;
  - typedef enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), synchronous active-low reset.
  - Reused for the input buffer.
  - Router core holds dispatch, slots and counters.

Test Plan:
1. Local delivery: LOCAL_ADDR=3, send 11'h185 ({4'h3,7'h05}) with sinks ready -> loc_valid two cycles after accept with loc_data=7'h05; loc_count=1; fwd_valid stays 0.
2. Forward delivery: send 11'h285 ({4'h5,7'h05}) -> fwd_data=11'h285 two cycles after accept; fwd_count=1; loc idle.
3. Backpressure: fwd_ready=0, send four forward packets 0x281..0x284 -> 0x281 held in slot, FIFO takes 0x282 and 0x283, in_ready=0 afterwards with 0x284 pending. Then fwd_ready=1 -> all four delivered in order on consecutive cycles.
4. Head-of-line blocking: fwd_ready=0, send forward 0x281 then forward 0x282 then local 0x185.
   - loc_valid stays 0 while 0x282 is stuck at the FIFO head.
   - Asserting fwd_ready releases 0x282 and then 0x185.
5. Counter wrap: CNT_W=2, deliver 5 local packets -> loc_count sequence 1,2,3,0,1.
6. Reset mid-operation: FIFO full and both slots valid, pulse _RESET low for one cycle.
   - Next cycle: valids 0, counters 0, in_ready=1.
   - No stale packet ever appears afterwards.
